// File: rtl/implication_trail.sv
// Implication trail for a DPLL-style solver: a stack of decision levels,
// each holding its decision variable and the mask of variables implied
// while that level was on top. A backtrack hands the top level's mask to
// the downstream backtrack stage and then drops the level.
module implication_trail #(
    parameter int VAR_NUM     = 8,
    parameter int VAR_NUM_LOG = 3,
    parameter int LEVEL_NUM   = 8,
    parameter int LEVEL_LOG   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   decide,
    input  logic [VAR_NUM_LOG-1:0] decide_var,
    input  logic                   imply_valid,
    input  logic [VAR_NUM_LOG-1:0] imply_var,
    input  logic                   backtrack_req,
    input  logic                   bt_done,
    output logic [VAR_NUM-1:0]     implication_reg,
    output logic [VAR_NUM_LOG-1:0] assign_variable,
    output logic [LEVEL_LOG-1:0]   level,
    output logic                   busy,
    output logic                   full,
    output logic                   overflow,
    output logic                   unsat
);

    typedef enum logic [1:0] {IDLE, LOAD, PRESENT, CLEAR} state_t;

    localparam logic [LEVEL_LOG-1:0] TOP_LEVEL = LEVEL_LOG'(LEVEL_NUM - 1);
    localparam logic [VAR_NUM-1:0]   ONE_BIT   = VAR_NUM'(1);

    state_t                 state, state_next;
    logic [VAR_NUM-1:0]     mask      [LEVEL_NUM];
    logic [VAR_NUM-1:0]     mask_next [LEVEL_NUM];
    logic [VAR_NUM_LOG-1:0] dvar      [LEVEL_NUM];
    logic [VAR_NUM_LOG-1:0] dvar_next [LEVEL_NUM];
    logic [VAR_NUM-1:0]     out_mask, out_mask_next;
    logic [VAR_NUM_LOG-1:0] avar_next;
    logic [LEVEL_LOG-1:0]   level_next, level_up, target;
    logic                   overflow_next, unsat_next;

    assign full            = (level == TOP_LEVEL);
    assign busy            = (state != IDLE);
    assign implication_reg = (state == PRESENT) ? out_mask : '0;
    assign level_up        = level + 1'b1;

    // State register; reset aborts any backtrack in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and datapath updates; a same-cycle implication follows a successful decide into the new level.
    always_comb begin
        state_next    = state;
        mask_next     = mask;
        dvar_next     = dvar;
        out_mask_next = out_mask;
        avar_next     = assign_variable;
        level_next    = level;
        overflow_next = overflow;
        unsat_next    = 1'b0;
        target        = level;
        case (state)
            IDLE: begin
                if (backtrack_req) begin
                    if (level != '0) state_next = LOAD;
                    else             unsat_next = 1'b1;
                end else begin
                    if (decide) begin
                        if (full) begin
                            overflow_next = 1'b1;
                        end else begin
                            level_next          = level_up;
                            target              = level_up;
                            mask_next[level_up] = '0;
                            dvar_next[level_up] = decide_var;
                        end
                    end
                    if (imply_valid)
                        mask_next[target] = mask_next[target] | (ONE_BIT << imply_var);
                end
            end
            LOAD: begin
                out_mask_next = mask[level] | (ONE_BIT << dvar[level]);
                avar_next     = dvar[level];
                state_next    = PRESENT;
            end
            PRESENT: begin
                if (bt_done) state_next = CLEAR;
            end
            CLEAR: begin
                mask_next[level] = '0;
                level_next       = level - 1'b1;
                out_mask_next    = '0;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Storage and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LEVEL_NUM; i++) begin
                mask[i] <= '0;
                dvar[i] <= '0;
            end
            out_mask        <= '0;
            assign_variable <= '0;
            level           <= '0;
            overflow        <= 1'b0;
            unsat           <= 1'b0;
        end else begin
            for (int i = 0; i < LEVEL_NUM; i++) begin
                mask[i] <= mask_next[i];
                dvar[i] <= dvar_next[i];
            end
            out_mask        <= out_mask_next;
            assign_variable <= avar_next;
            level           <= level_next;
            overflow        <= overflow_next;
            unsat           <= unsat_next;
        end
    end

endmodule

// File: doc/implication_trail.md
IMPLICATION_TRAIL -- requirements
Module: implication_trail

Interface
REQ-001 Parameter VAR_NUM, default 8, sets the number of variables and the width of the implication mask.
REQ-002 Parameter VAR_NUM_LOG, default 3, sets the width of a variable index.
REQ-003 Parameter LEVEL_NUM, default 8, sets the number of decision levels stored, including root level 0.
REQ-004 Parameter LEVEL_LOG, default 3, sets the width of the level index.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 decide  input  1  pulse: open a new decision level for decide_var.
REQ-008 decide_var  input  VAR_NUM_LOG  decision variable index.
REQ-009 imply_valid  input  1  pulse: record imply_var as implied in the current level.
REQ-010 imply_var  input  VAR_NUM_LOG  implied variable index.
REQ-011 backtrack_req  input  1  pulse: undo the top decision level.
REQ-012 bt_done  input  1  downstream backtrack stage has finished rewriting the assignment table.
REQ-013 implication_reg  output  VAR_NUM  mask of variables to unassign; nonzero only while presenting.
REQ-014 assign_variable  output  VAR_NUM_LOG  decision variable of the level being undone.
REQ-015 level  output  LEVEL_LOG  current decision level.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 full  output  1  high when level == LEVEL_NUM-1.
REQ-018 overflow  output  1  sticky; set when decide is issued while full.
REQ-019 unsat  output  1  one-cycle pulse when backtrack_req is issued at level 0.

Function
REQ-020 Storage: LEVEL_NUM masks of VAR_NUM bits and LEVEL_NUM decision indices of VAR_NUM_LOG bits, both register-based.
REQ-021 FSM states: IDLE, LOAD, PRESENT, CLEAR.
REQ-022 In IDLE, decide with full low: level increments, mask[level+1] clears, dvar[level+1] <= decide_var; the new level is visible next cycle.
REQ-023 In IDLE, imply_valid: mask[level][imply_var] <= 1; a bit that is already set stays set.
REQ-024 decide and imply_valid in the same cycle: the implication goes into the new level (level+1).
REQ-025 decide with full high: level is unchanged, overflow is set, and any same-cycle imply goes into the current level.
REQ-026 backtrack_req in IDLE with level > 0: go to LOAD; decide and imply_valid in that cycle are ignored.
REQ-027 backtrack_req in IDLE with level == 0: unsat pulses for one cycle, the FSM stays in IDLE, and storage is unchanged.
REQ-028 LOAD (1 cycle): latch out_mask <= mask[level] | onehot(dvar[level]) and assign_variable <= dvar[level], then go to PRESENT.
REQ-029 PRESENT: implication_reg = out_mask; hold until bt_done == 1, then go to CLEAR.
REQ-030 CLEAR (1 cycle): mask[level] clears, level decrements, out_mask clears, then go to IDLE.
REQ-031 implication_reg = 0 in IDLE, LOAD and CLEAR.
REQ-032 decide, imply_valid and backtrack_req are ignored in every state other than IDLE; the driver must check busy.
REQ-033 bt_done is ignored in every state other than PRESENT.
REQ-034 Minimum backtrack latency: 3 cycles from backtrack_req to return to IDLE, when bt_done is already high on entry to PRESENT.
REQ-035 Level 0 has no decision variable; dvar[0] is never used.

Reset
REQ-036 rst clears all masks, dvar entries, out_mask, level, overflow and unsat; FSM goes to IDLE; implication_reg = 0, assign_variable = 0, busy = 0, full = 0.
REQ-037 rst asserted during LOAD, PRESENT or CLEAR aborts immediately; the partial backtrack leaves no trace.

Verification
REQ-038 After reset: imply 2, imply 5, decide 3, imply 1, backtrack_req, then bt_done in PRESENT.
- While in PRESENT: implication_reg = 8'b0000_1010 and assign_variable = 3.
- After CLEAR: level = 0, and mask[0] still reads 8'b0010_0100 on the next backtrack attempt (that attempt gives an unsat pulse).
REQ-039 decide 4 and imply 6 in the same cycle, then backtrack: implication_reg = 8'b0101_0000.
REQ-040 Issue 8 decides (full after the 7th): level = 7, full = 1, overflow = 1 after the 8th, level stays 7.
REQ-041 Backtrack with bt_done held low for 10 cycles: implication_reg is stable and busy = 1 throughout; decide and imply issued meanwhile leave level and masks unchanged.
REQ-042 backtrack_req at level 0: unsat is high for exactly 1 cycle, busy stays 0, implication_reg stays 0.
REQ-043 rst asserted in PRESENT: next cycle implication_reg = 0, level = 0, busy = 0; a later backtrack_req gives unsat.
